// File: rtl/qsys1_pio_arbiter_if.sv
// Avalon-MM master port bundle between one requester and the PIO arbiter.
// The arbiter takes the slave modport, the requester side takes the master modport.
interface qsys1_pio_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output address, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/qsys1_pio_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single PIO s1 port; one access per three cycles.
// Define PIO_ARB_FIXED_PRIO_EN for fixed m0 priority instead of the default round-robin.
//
// state | meaning
// IDLE  | waiting for a request; winner latched on the leaving edge
// ISSUE | PIO access driven for one cycle; readdata captured on the leaving edge
// ACK   | granted master sees waitrequest low and the captured readdata
module qsys1_pio_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    qsys1_pio_arbiter_if.slave m0,
    qsys1_pio_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]  s_address,
    output logic               s_chipselect,
    output logic               s_write_n,
    output logic [DATA_W-1:0]  s_writedata,
    input  logic [DATA_W-1:0]  s_readdata,
    output logic               grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              grant_q;
    logic              last_grant_q;
    logic              is_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic req0, req1, win, accept;
    logic m0_wait, m1_wait;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

`ifdef PIO_ARB_FIXED_PRIO_EN
    // m1 only wins when m0 is not asking at all
    assign win = ~req0;
`else
    assign win = (req0 & req1) ? ~last_grant_q : req1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
        m0_wait      = 1'b1;
        m1_wait      = 1'b1;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                s_chipselect = 1'b1;
                s_write_n    = ~is_write_q;
                state_d      = ACK;
            end
            ACK: begin
                m0_wait = grant_q;
                m1_wait = ~grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A master asserting read and write together is served as a write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            is_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            if (accept) begin
                grant_q    <= win;
                addr_q     <= win ? m1.address   : m0.address;
                wdata_q    <= win ? m1.writedata : m0.writedata;
                is_write_q <= win ? m1.write     : m0.write;
            end
            if (state_q == ISSUE) begin
                rdata_q      <= s_readdata;
                last_grant_q <= grant_q;
            end
        end
    end

    assign s_address      = addr_q;
    assign s_writedata    = wdata_q;
    assign grant          = grant_q;
    assign m0.readdata    = rdata_q;
    assign m1.readdata    = rdata_q;
    assign m0.waitrequest = m0_wait;
    assign m1.waitrequest = m1_wait;

endmodule

// File: tb/tb_qsys1_pio_arbiter.sv
// Bench for qsys1_pio_arbiter: directed and random traffic against a transaction-timed model.
// Honours PIO_ARB_FIXED_PRIO_EN the same way the design does.
module tb_qsys1_pio_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    qsys1_pio_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) m0_bus ();
    qsys1_pio_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) m1_bus ();

    logic [ADDR_W-1:0] s_address;
    logic              s_chipselect;
    logic              s_write_n;
    logic [DATA_W-1:0] s_writedata;
    logic [DATA_W-1:0] s_readdata;
    logic              grant;

    qsys1_pio_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .m0           (m0_bus),
        .m1           (m1_bus),
        .s_address    (s_address),
        .s_chipselect (s_chipselect),
        .s_write_n    (s_write_n),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .grant        (grant)
    );

    // PIO slave: one data register at address 0, other addresses read zero, no reset
    logic [DATA_W-1:0] pio_q = '0;
    always @(posedge clk)
        if (s_chipselect && !s_write_n && s_address == 2'd0) pio_q <= s_writedata;
    assign s_readdata = (s_address == 2'd0) ? pio_q : '0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    endtask

    // requester stimulus
    logic        req_rd    [2] = '{default: 1'b0};
    logic        req_wr    [2] = '{default: 1'b0};
    logic [1:0]  req_addr  [2] = '{default: 2'd0};
    logic [31:0] req_wdata [2] = '{default: 32'd0};
    bit          cont_mode = 1'b0;
    bit          rand_mode = 1'b0;
    bit          ack_seen  [2];
    logic [31:0] ack_rdata [2];

    // reference model: a transaction accepted at cycle t is on the PIO in t+1 and acked in t+2
    int          cyc     = 0;
    bit          m_busy  = 1'b0;
    int          m_tacc  = 0;
    bit          m_own   = 1'b0;
    bit          m_last  = 1'b1;
    bit          m_wr    = 1'b0;
    logic [1:0]  m_addr  = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata = '0;
    logic [31:0] pio_exp = '0;

    task automatic drive();
        m0_bus.read      = req_rd[0];
        m0_bus.write     = req_wr[0];
        m0_bus.address   = req_addr[0];
        m0_bus.writedata = req_wdata[0];
        m1_bus.read      = req_rd[1];
        m1_bus.write     = req_wr[1];
        m1_bus.address   = req_addr[1];
        m1_bus.writedata = req_wdata[1];
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_own   = 1'b0;
        m_last  = 1'b1;
        m_rdata = '0;
    endtask

    task automatic check_cycle();
        int k;
        bit iss, ack, r0, r1, w;
        k   = cyc - m_tacc;
        iss = m_busy && (k == 1);
        ack = m_busy && (k == 2);
        chk("s_chipselect", 32'(s_chipselect), 32'(iss));
        chk("s_write_n", 32'(s_write_n), 32'(!(iss && m_wr)));
        if (iss) begin
            chk("s_address", 32'(s_address), 32'(m_addr));
            chk("s_writedata", s_writedata, m_wdata);
        end
        chk("m0_waitrequest", 32'(m0_bus.waitrequest), 32'(!(ack && !m_own)));
        chk("m1_waitrequest", 32'(m1_bus.waitrequest), 32'(!(ack && m_own)));
        chk("m0_readdata", m0_bus.readdata, m_rdata);
        chk("m1_readdata", m1_bus.readdata, m_rdata);
        chk("grant", 32'(grant), 32'(m_own));
        ack_seen[0]  = !m0_bus.waitrequest;
        ack_seen[1]  = !m1_bus.waitrequest;
        ack_rdata[0] = m0_bus.readdata;
        ack_rdata[1] = m1_bus.readdata;
        if (iss) begin
            m_rdata = (m_addr == 2'd0) ? pio_exp : 32'd0;
            if (m_wr && m_addr == 2'd0) pio_exp = m_wdata;
            m_last = m_own;
        end
        if (ack) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            r0 = req_rd[0] | req_wr[0];
            r1 = req_rd[1] | req_wr[1];
            if (r0 | r1) begin
`ifdef PIO_ARB_FIXED_PRIO_EN
                w = !r0;
`else
                w = (r0 && r1) ? !m_last : r1;
`endif
                m_busy  = 1'b1;
                m_tacc  = cyc;
                m_own   = w;
                m_wr    = req_wr[w];
                m_addr  = req_addr[w];
                m_wdata = req_wdata[w];
            end
        end
        cyc++;
    endtask

    task automatic update_masters();
        int op;
        for (int k = 0; k < 2; k++) begin
            if (ack_seen[k] && !cont_mode) begin
                req_rd[k] = 1'b0;
                req_wr[k] = 1'b0;
            end
            if (rand_mode && !req_rd[k] && !req_wr[k] && $urandom_range(0, 2) == 0) begin
                op           = int'($urandom_range(0, 3));
                req_rd[k]    = (op == 0 || op == 2);
                req_wr[k]    = (op != 0);
                req_addr[k]  = 2'($urandom_range(0, 1));
                req_wdata[k] = $urandom;
            end
        end
        drive();
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        update_masters();
    endtask

    task automatic issue(input int k, input bit rd, input bit wr, input logic [1:0] a,
                         input logic [31:0] d, output int lat, output logic [31:0] rdata);
        req_rd[k]    = rd;
        req_wr[k]    = wr;
        req_addr[k]  = a;
        req_wdata[k] = d;
        drive();
        lat   = 0;
        rdata = '0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (ack_seen[k]) begin
                lat   = n;
                rdata = ack_rdata[k];
                break;
            end
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_cs"}, 32'(s_chipselect), 32'd0);
        chk({tag, "_write_n"}, 32'(s_write_n), 32'd1);
        chk({tag, "_addr"}, 32'(s_address), 32'd0);
        chk({tag, "_wdata"}, s_writedata, 32'd0);
        chk({tag, "_wait0"}, 32'(m0_bus.waitrequest), 32'd1);
        chk({tag, "_wait1"}, 32'(m1_bus.waitrequest), 32'd1);
        chk({tag, "_rdata0"}, m0_bus.readdata, 32'd0);
        chk({tag, "_rdata1"}, m1_bus.readdata, 32'd0);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, n_ack0, n_ack1, first_own;
        logic [31:0] rd;

        drive();
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (10) step();

        issue(0, 1'b0, 1'b1, 2'd0, 32'hDEADBEEF, lat, rd);
        chk("wr_latency", 32'(lat), 32'd3);
        chk("pio_deadbeef", pio_q, 32'hDEADBEEF);
        issue(1, 1'b1, 1'b0, 2'd0, 32'h0, lat, rd);
        chk("rd0_latency", 32'(lat), 32'd3);
        chk("rd0_data", rd, 32'hDEADBEEF);
        issue(1, 1'b1, 1'b0, 2'd1, 32'h0, lat, rd);
        chk("rd1_data", rd, 32'd0);
        issue(0, 1'b1, 1'b1, 2'd0, 32'h55, lat, rd);
        chk("rdwr_latency", 32'(lat), 32'd3);
        chk("pio_55", pio_q, 32'h55);
        issue(1, 1'b1, 1'b0, 2'd0, 32'h0, lat, rd);
        chk("rd_55", rd, 32'h55);

        // reset pulse in the middle of a write's ISSUE cycle
        req_rd[0]    = 1'b0;
        req_wr[0]    = 1'b1;
        req_addr[0]  = 2'd0;
        req_wdata[0] = 32'h1234;
        drive();
        step();
        chk("mid_issue_cs", 32'(s_chipselect), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        reset_checks("async_reset");
        req_wr[0] = 1'b0;
        drive();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("pio_write_dropped", pio_q, 32'h55);
        repeat (5) step();

        // continuous contention, both masters writing
        cont_mode = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_rd[k]    = 1'b0;
            req_wr[k]    = 1'b1;
            req_addr[k]  = 2'd0;
            req_wdata[k] = (k == 0) ? 32'h1 : 32'h2;
        end
        drive();
        n_ack0    = 0;
        n_ack1    = 0;
        first_own = -1;
        repeat (24) begin
            step();
            if (ack_seen[0]) n_ack0++;
            if (ack_seen[1]) n_ack1++;
            if (first_own < 0 && ack_seen[0]) first_own = 0;
            if (first_own < 0 && ack_seen[1]) first_own = 1;
        end
        cont_mode = 1'b0;
        repeat (12) step();
        chk("cont_first", 32'(first_own), 32'd0);
`ifdef PIO_ARB_FIXED_PRIO_EN
        chk("cont_m0_acks", 32'(n_ack0), 32'd8);
        chk("cont_m1_acks", 32'(n_ack1), 32'd0);
`else
        chk("cont_m0_acks", 32'(n_ack0), 32'd4);
        chk("cont_m1_acks", 32'(n_ack1), 32'd4);
`endif
        chk("cont_drained", 32'({req_rd[0], req_wr[0], req_rd[1], req_wr[1]}), 32'd0);

        rand_mode = 1'b1;
        repeat (1500) step();
        rand_mode = 1'b0;
        repeat (12) step();
        chk("rand_drained", 32'({req_rd[0], req_wr[0], req_rd[1], req_wr[1]}), 32'd0);
        chk("pio_final", pio_q, pio_exp);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
